// File: rtl/modn_seq_checker_if.sv
// Sample/result bundle between a mod-N count source and modn_seq_checker.
// The source drives the sample side; the checker drives the status side.
interface modn_seq_checker_if #(
  parameter int unsigned MSB   = 4,
  parameter int unsigned ERRW  = 8,
  parameter int unsigned WRAPW = 16
);
  logic             in_valid;
  logic [MSB-1:0]   count_in;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic             err_range;
  logic [ERRW-1:0]  err_count;
  logic [WRAPW-1:0] wrap_count;
  logic [MSB-1:0]   expected;

  modport master (
    output in_valid, count_in, clear,
    input  locked, err_pulse, err_range, err_count, wrap_count, expected
  );

  modport slave (
    input  in_valid, count_in, clear,
    output locked, err_pulse, err_range, err_count, wrap_count, expected
  );
endinterface

// File: rtl/modn_seq_checker.sv
// Locks onto a valid-qualified mod-N count stream and flags sequence/range errors.
// Counts terminal-count wraps while locked; error total saturates.
module modn_seq_checker #(
  parameter int unsigned N        = 10,
  parameter int unsigned MSB      = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERRW     = 8,
  parameter int unsigned WRAPW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  modn_seq_checker_if.slave  bus
);
  localparam int unsigned    MCW  = $clog2(LOCK_CNT + 1);
  localparam logic [MSB-1:0] LAST = MSB'(N - 1);
  localparam logic [MSB:0]   MODV = (MSB + 1)'(N);
  localparam logic [MCW-1:0] LOCK = MCW'(LOCK_CNT);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [MCW-1:0]   match_cnt_q, match_cnt_d;
  logic [MSB-1:0]   expected_q, expected_d;
  logic [ERRW-1:0]  err_count_q, err_count_d;
  logic [WRAPW-1:0] wrap_count_q, wrap_count_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_range_q, err_range_d;

  logic             out_of_range_c;
  logic             hit_c;
  logic [MSB-1:0]   seed_nxt_c;
  logic [ERRW-1:0]  err_inc_c;
  logic [MCW-1:0]   match_inc_c;

  function automatic logic [MSB-1:0] nxt(input logic [MSB-1:0] v);
    return (v == LAST) ? '0 : v + MSB'(1);
  endfunction

  // One extra bit so N == 2**MSB never flags a range error.
  assign out_of_range_c = ({1'b0, bus.count_in} >= MODV);
  assign hit_c          = (bus.count_in == expected_q);
  assign seed_nxt_c     = nxt(bus.count_in);
  assign err_inc_c      = (err_count_q == '1) ? err_count_q : err_count_q + ERRW'(1);
  assign match_inc_c    = match_cnt_q + MCW'(1);

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    expected_d   = expected_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    err_pulse_d  = 1'b0;
    err_range_d  = err_range_q;

    if (bus.clear) begin
      state_d      = HUNT;
      match_cnt_d  = '0;
      expected_d   = '0;
      err_count_d  = '0;
      wrap_count_d = '0;
    end else if (bus.in_valid) begin
      if (out_of_range_c) begin
        err_pulse_d = 1'b1;
        err_range_d = 1'b1;
        err_count_d = err_inc_c;
        state_d     = HUNT;
        match_cnt_d = '0;
      end else begin
        expected_d = seed_nxt_c;
        unique case (state_q)
          HUNT: begin
            state_d     = SYNC;
            match_cnt_d = MCW'(1);
          end
          SYNC: begin
            if (hit_c) begin
              match_cnt_d = match_inc_c;
              if (match_inc_c == LOCK) state_d = LOCKED;
            end else begin
              match_cnt_d = MCW'(1);
            end
          end
          LOCKED: begin
            if (hit_c) begin
              if (bus.count_in == LAST) wrap_count_d = wrap_count_q + WRAPW'(1);
            end else begin
              err_pulse_d = 1'b1;
              err_range_d = 1'b0;
              err_count_d = err_inc_c;
              state_d     = SYNC;
              match_cnt_d = MCW'(1);
            end
          end
          default: begin
            state_d     = HUNT;
            match_cnt_d = '0;
          end
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      match_cnt_q  <= '0;
      expected_q   <= '0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      expected_q   <= expected_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_range_q  <= err_range_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_range  = err_range_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;
  assign bus.expected   = expected_q;
endmodule

// File: tb/tb_modn_seq_checker.sv
// Directed scoreboard bench for modn_seq_checker (N=10, LOCK_CNT=3).
module tb_modn_seq_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string name;
    int    lock;
    int    pulse;
    int    range;  // -1 = not checked
    int    err;
    int    wrap;
    int    exp;    // -1 = not checked
  } exp_t;

  exp_t sb_q[$];

  modn_seq_checker_if #(.MSB(4), .ERRW(8), .WRAPW(16)) bus ();

  modn_seq_checker #(.N(10), .MSB(4), .LOCK_CNT(3), .ERRW(8), .WRAPW(16)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue the response it must produce.
  task automatic step(input string name, input logic v, input int c, input logic clr,
                      input int lk, input int p, input int r, input int e,
                      input int w, input int x);
    exp_t ex;
    @(negedge clk);
    bus.in_valid = v;
    bus.count_in = 4'(c);
    bus.clear    = clr;
    ex.name = name; ex.lock = lk; ex.pulse = p; ex.range = r;
    ex.err = e; ex.wrap = w; ex.exp = x;
    sb_q.push_back(ex);
  endtask

  // Monitor: outputs are compared just after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".locked"}, int'(bus.locked), e.lock);
        chk({e.name, ".err_pulse"}, int'(bus.err_pulse), e.pulse);
        if (e.range >= 0) chk({e.name, ".err_range"}, int'(bus.err_range), e.range);
        chk({e.name, ".err_count"}, int'(bus.err_count), e.err);
        chk({e.name, ".wrap_count"}, int'(bus.wrap_count), e.wrap);
        if (e.exp >= 0) chk({e.name, ".expected"}, int'(bus.expected), e.exp);
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, ".locked"}, int'(bus.locked), 0);
    chk({name, ".err_pulse"}, int'(bus.err_pulse), 0);
    chk({name, ".err_range"}, int'(bus.err_range), 0);
    chk({name, ".err_count"}, int'(bus.err_count), 0);
    chk({name, ".wrap_count"}, int'(bus.wrap_count), 0);
    chk({name, ".expected"}, int'(bus.expected), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.count_in = '0;
    bus.clear    = 1'b0;

    // 1. Reset then lock on 0,1,2
    #1;
    check_all_zero("reset_early");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("lock_s0", 1, 0, 0, 0, 0, -1, 0, 0, 1);
    step("lock_s1", 1, 1, 0, 0, 0, -1, 0, 0, 2);
    step("lock_s2", 1, 2, 0, 1, 0, -1, 0, 0, 3);
    step("lock_s3", 1, 3, 0, 1, 0, -1, 0, 0, 4);
    step("lock_s4", 1, 4, 0, 1, 0, -1, 0, 0, 5);

    // 3. Mismatch while locked (expected 5, feed 7), relock on 8,9
    step("mis_7", 1, 7, 0, 0, 1, 0, 1, 0, 8);
    step("mis_8", 1, 8, 0, 0, 0, -1, 1, 0, 9);
    step("mis_9", 1, 9, 0, 1, 0, -1, 1, 0, 0);

    // 2. Two full wraps then a 0
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 10; v++)
        step($sformatf("wrap_r%0d_v%0d", r, v), 1, v, 0, 1, 0, -1, 1,
             r + ((v == 9) ? 1 : 0), (v + 1) % 10);
    step("wrap_end", 1, 0, 0, 1, 0, -1, 1, 2, 1);

    // 4. Out-of-range while locked, back-to-back, then relock
    step("rng_12", 1, 12, 0, 0, 1, 1, 2, 2, -1);
    step("rng_13", 1, 13, 0, 0, 1, 1, 3, 2, -1);
    step("rng_4", 1, 4, 0, 0, 0, -1, 3, 2, 5);
    step("rng_5", 1, 5, 0, 0, 0, -1, 3, 2, 6);
    step("rng_6", 1, 6, 0, 1, 0, -1, 3, 2, 7);

    // 5. Clear, gapped stream, then clear with a colliding sample
    step("clr_a", 0, 0, 1, 0, 0, -1, 0, 0, 0);
    step("gap_3", 1, 3, 0, 0, 0, -1, 0, 0, 4);
    for (int g = 0; g < 5; g++)
      step($sformatf("gap_idle%0d", g), 0, 12, 0, 0, 0, -1, 0, 0, 4);
    step("gap_4", 1, 4, 0, 0, 0, -1, 0, 0, 5);
    step("gap_5", 1, 5, 0, 1, 0, -1, 0, 0, 6);
    step("clr_b", 1, 9, 1, 0, 0, -1, 0, 0, 0);
    step("post_clr_0", 1, 0, 0, 0, 0, -1, 0, 0, 1);
    step("post_clr_1", 1, 1, 0, 0, 0, -1, 0, 0, 2);
    step("post_clr_2", 1, 2, 0, 1, 0, -1, 0, 0, 3);

    // 6. Saturate the error counter with range errors
    step("sat_clr", 0, 0, 1, 0, 0, -1, 0, 0, 0);
    for (int i = 1; i <= 300; i++)
      step($sformatf("sat_%0d", i), 1, 15, 0, 0, 1, 1, (i > 255) ? 255 : i, 0, -1);
    step("sat_hold", 0, 0, 0, 0, 0, 1, 255, 0, -1);

    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    // Async reset mid-cycle clears without a clock edge
    @(posedge clk);
    #3;
    chk("pre_rst.err_count", int'(bus.err_count), 255);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modn_seq_checker.md
# modN_seq_checker

- Receive-side companion to `sync_modN_counter`.
- Samples a mod-N count stream qualified by a valid strobe and locks onto the sequence.
- Verifies that every later sample is the previous one plus one, modulo N.
- Reports sequence and range errors and counts terminal-count wraps.
- Sits downstream of any mod-N counter (same or remote clock-enabled domain, already synchronised) as a built-in self-check and monitor.

## Interface

Parameters:

- N, 10, modulus of the checked sequence (2..2^MSB)
- MSB, 4, width of the count bus
- LOCK_CNT, 3, number of consecutive in-sequence samples (including the seed) needed to lock; ≥2
- ERRW, 8, width of the saturating error counter
- WRAPW, 16, width of the wrap counter

Ports:

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  count_in is sampled on this cycle
- count_in  in  MSB  count value under check
- clear  in  1  synchronous: zero counters, return to HUNT
- locked  out  1  sequence lock achieved
- err_pulse  out  1  one-cycle error strobe
- err_range  out  1  qualifies err_pulse: 1 = value ≥ N, 0 = sequence mismatch
- err_count  out  ERRW  saturating error total
- wrap_count  out  WRAPW  terminal-count occurrences while locked (rolls over)
- expected  out  MSB  next value the checker expects

## Operation

States:

- HUNT: no seed held.
- SYNC: seed taken, accumulating matches; internal match_cnt.
- LOCKED: sequence locked.

Next-value rule: nxt(v) = (v == N-1) ? 0 : v+1. Compute at MSB bits; no wider arithmetic needed.

Every sample with in_valid=1 is classified as follows:

- **Range check, any state:** count_in ≥ N gives err_pulse=1, err_range=1, err_count+1, then go to HUNT, locked=0.
- **HUNT, in-range sample s:** go to SYNC, match_cnt=1, expected=nxt(s). No error.
- **SYNC, sample == expected:**
  - match_cnt+1.
  - If the new match_cnt == LOCK_CNT, go to LOCKED.
  - expected=nxt(sample).
- **SYNC, in-range mismatch:** no error. Re-seed: match_cnt=1, expected=nxt(sample), stay in SYNC.
- **LOCKED, sample == expected:**
  - expected=nxt(sample).
  - If the sample == N-1, wrap_count+1 (modulo 2^WRAPW).
- **LOCKED, in-range mismatch:**
  - err_pulse=1, err_range=0, err_count+1.
  - Go to SYNC with the sample as seed: match_cnt=1, expected=nxt(sample), locked=0.

Other rules:

- **in_valid=0:** hold all state. err_pulse=0.
- **err_count:** saturates at all-ones and does not roll over.
- **clear=1:**
  - HUNT, match_cnt=0, err_count=0, wrap_count=0, expected=0, err_pulse=0.
  - clear has priority over in_valid; a sample presented in the same cycle is discarded.
- **Reset values (rst=0, asynchronous):**
  - locked=0, err_pulse=0, err_range=0, err_count=0, wrap_count=0, expected=0.
  - State HUNT, match_cnt=0.

## Timing

- All outputs are registered and update on the rising clk edge that samples the qualifying input. Latency is 1 cycle from the sample to the output change.
- err_pulse is high exactly one cycle per erroneous sample. Back-to-back bad samples give back-to-back pulses.
- err_range is valid only when err_pulse=1 and holds its last value otherwise.
- locked rises on the edge that samples the LOCK_CNT-th consecutive in-sequence value, and falls on the edge that samples an erroneous value.
- No throughput limit: in_valid may be high every cycle.
- rst asserted mid-stream clears immediately, with no clock needed. Deassertion is synchronised externally. The first sample is accepted on the first edge after release.

## Test plan

All scenarios use the defaults N=10, LOCK_CNT=3.

1. **Reset and lock:**
   - Stimulus: rst low for 2 cycles, then release. in_valid=1 with 0,1,2,3…
   - Required: all outputs 0 during reset. locked=1 after the edge sampling 2; expected=3 then.
2. **Wrap:**
   - Stimulus: stream 0..9,0..9,0.
   - Required: wrap_count=2, err_count=0, locked stays 1, expected=1.
3. **Mismatch while locked:**
   - Stimulus: once locked at expected=5, feed 7, then 8, 9.
   - Required:
     - One err_pulse with err_range=0, err_count=1, locked=0.
     - locked=1 again after the edge sampling 9; expected=0.
4. **Out-of-range:**
   - Stimulus: feed 12 while locked, then 13.
   - Required:
     - Two consecutive err_pulse cycles with err_range=1, err_count=2, state HUNT, locked=0.
     - Then 4,5,6 relocks.
5. **Gaps and clear:**
   - Stimulus: stream 3,4 with in_valid=0 for 5 cycles between them, then 5.
   - Required: locked=1, no error.
   - Then clear=1 together with in_valid=1 and count_in=9.
   - Required: all counters 0, locked=0, expected=0, sample ignored.
6. **Saturation and async reset:**
   - Stimulus: force 300 range errors.
   - Required: err_count=255 and holds.
   - Then assert rst between clock edges.
   - Required: err_count=0 immediately, before the next edge.
